// File: rtl/pc_fetch_pkg.sv
// Shared constants and fetch-state encoding for the fetch stage and its pipeline latches.
// The optional PC_FETCH_CHECK_EN build adds a sticky fetch_err output to pc_fetch.
package pc_fetch_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Saturating increment shared by the fetch counter and any later event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID pipeline latch: holds on stall, clears to a bubble on flush, else loads.
// Generic enough to reuse for the later pipeline latches.
module if_id_reg
  import pc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Stall has priority: a flush arriving during a stall is dropped.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (!stall_i) begin
      if (flush_i) begin
        instr_d = NOP_INSTR;
        pc_d    = 32'h0;
        valid_d = 1'b0;
      end else begin
        instr_d = valid_i ? instr_i : NOP_INSTR;
        pc_d    = pc_i;
        valid_d = valid_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: architectural PC, instruction-memory addressing, IF/ID latch, sequencing FSM
// and a saturating fetch counter. Define PC_FETCH_CHECK_EN to add the fetch_err range check.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEFAULT,
  parameter int          ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       npc_in,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc_f,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       instr_d,
  output logic [31:0]       pc_d,
  output logic              valid_d,
  output logic [31:0]       fetch_cnt,
  output logic [1:0]        fetch_state
`ifdef PC_FETCH_CHECK_EN
  ,
  output logic              fetch_err
`endif
);

  logic [31:0]  pc_q;
  logic [31:0]  cnt_q;
  fetch_state_e state_q;

  logic [31:0]  pc_off;
  logic         flush_eff;
  logic         load_valid;
  logic         counts;

  // Word address relative to the memory base; wraps silently outside the memory.
  assign pc_off    = pc_f - IMEM_BASE;
  assign imem_addr = ADDR_W'(pc_off >> 2);

  // The very first load after reset always fetches, so flush only acts once running.
  assign flush_eff = flush && (state_q != ST_BOOT);

`ifdef PC_FETCH_CHECK_EN
  logic err_q;
  logic bad_pc;

  assign bad_pc     = (pc_f[1:0] != 2'b00) || ((pc_off >> (ADDR_W + 2)) != 32'h0);
  assign load_valid = !bad_pc;
  assign fetch_err  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (!stall && !flush_eff && bad_pc) begin
      err_q <= 1'b1;
    end
  end
`else
  assign load_valid = 1'b1;
`endif

  assign counts = !stall && !flush_eff && load_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      cnt_q   <= 32'h0;
      state_q <= ST_BOOT;
    end else begin
      if (!stall) begin
        pc_q <= npc_in;
      end
      if (counts) begin
        cnt_q <= sat_inc32(cnt_q);
      end
      case (state_q)
        ST_BOOT: state_q <= stall ? ST_BOOT : ST_RUN;
        ST_RUN:  state_q <= stall ? ST_HOLD : ST_RUN;
        ST_HOLD: state_q <= stall ? ST_HOLD : ST_RUN;
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (reset),
    .stall_i (stall),
    .flush_i (flush_eff),
    .valid_i (load_valid),
    .instr_i (imem_rdata),
    .pc_i    (pc_f),
    .instr_o (instr_d),
    .pc_o    (pc_d),
    .valid_o (valid_d)
  );

  assign pc_f        = pc_q;
  assign fetch_cnt   = cnt_q;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, sequential fetch, redirect, stall/flush interplay,
// async reset during HOLD, and wrapped / checked out-of-range addressing.
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] npc_in;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [11:0] imem_addr;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] fetch_cnt;
  logic [1:0]  fetch_state;
`ifdef PC_FETCH_CHECK_EN
  logic        fetch_err;
`endif

  logic        npc_force;
  logic [31:0] npc_val;

  int checks;
  int errors;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pc_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .npc_in      (npc_in),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .imem_addr   (imem_addr),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .valid_d     (valid_d),
    .fetch_cnt   (fetch_cnt),
    .fetch_state (fetch_state)
`ifdef PC_FETCH_CHECK_EN
    ,
    .fetch_err   (fetch_err)
`endif
  );

  // Instruction memory model: word k holds A000_0000 + k.
  assign imem_rdata = 32'hA000_0000 | {20'h0, imem_addr};
  // Next-PC logic model: sequential unless the step forces a redirect target.
  assign npc_in = npc_force ? npc_val : pc_f + 32'd4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pcd,
                         input logic [31:0] e_instr, input logic e_valid,
                         input logic [31:0] e_cnt, input logic [1:0] e_state);
    chk({tag, ".pc_f"},  pc_f, e_pc);
    chk({tag, ".pc_d"},  pc_d, e_pcd);
    chk({tag, ".instr"}, instr_d, e_instr);
    chk({tag, ".valid"}, {31'h0, valid_d}, {31'h0, e_valid});
    chk({tag, ".cnt"},   fetch_cnt, e_cnt);
    chk({tag, ".state"}, {30'h0, fetch_state}, {30'h0, e_state});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    npc_force = 1'b0;
    npc_val   = 32'h0;

    tick();
    tick();
    chk_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0, S_BOOT);
    chk("reset.addr", {20'h0, imem_addr}, 32'h0);
`ifdef PC_FETCH_CHECK_EN
    chk("reset.err", {31'h0, fetch_err}, 32'h0);
`endif
    reset = 1'b0;

    // BOOT load, then sequential fetch
    tick();
    chk_all("boot", 32'h3004, 32'h3000, 32'hA000_0000, 1'b1, 32'd1, S_RUN);
    tick();
    chk_all("seq", 32'h3008, 32'h3004, 32'hA000_0001, 1'b1, 32'd2, S_RUN);
    chk("seq.addr", {20'h0, imem_addr}, 32'h2);

    // Redirect to 0x3040; the instruction at 0x3008 is still delivered
    npc_force = 1'b1;
    npc_val   = 32'h3040;
    tick();
    npc_force = 1'b0;
    chk_all("redir", 32'h3040, 32'h3008, 32'hA000_0002, 1'b1, 32'd3, S_RUN);
    chk("redir.addr", {20'h0, imem_addr}, 32'h10);
    tick();
    chk_all("after_redir", 32'h3044, 32'h3040, 32'hA000_0010, 1'b1, 32'd4, S_RUN);

    // Three stall cycles freeze everything
    stall = 1'b1;
    tick();
    chk_all("stall1", 32'h3044, 32'h3040, 32'hA000_0010, 1'b1, 32'd4, S_HOLD);
    tick();
    tick();
    chk_all("stall3", 32'h3044, 32'h3040, 32'hA000_0010, 1'b1, 32'd4, S_HOLD);
    stall = 1'b0;
    tick();
    chk_all("resume", 32'h3048, 32'h3044, 32'hA000_0011, 1'b1, 32'd5, S_RUN);

    // stall+flush: stall wins, flush dropped
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk_all("stall_flush", 32'h3048, 32'h3044, 32'hA000_0011, 1'b1, 32'd5, S_HOLD);

    // flush alone from HOLD: bubble, PC still advances
    stall = 1'b0;
    tick();
    chk_all("flush", 32'h304C, 32'h0, 32'h0, 1'b0, 32'd5, S_RUN);
    flush = 1'b0;
    tick();
    chk_all("post_flush", 32'h3050, 32'h304C, 32'hA000_0013, 1'b1, 32'd6, S_RUN);

    // Async reset mid-cycle during HOLD
    stall = 1'b1;
    tick();
    tick();
    chk("hold_before_rst.state", {30'h0, fetch_state}, {30'h0, S_HOLD});
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0, S_BOOT);
    tick();
    reset = 1'b0;

    // Stall while in BOOT holds BOOT
    tick();
    chk_all("boot_stall", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0, S_BOOT);
    stall = 1'b0;
    tick();
    chk_all("boot2", 32'h3004, 32'h3000, 32'hA000_0000, 1'b1, 32'd1, S_RUN);

    // Misaligned PC, then out-of-range PC (wraps to word 0 without the check)
    npc_force = 1'b1;
    npc_val   = 32'h3002;
    tick();
    chk_all("mis_pc", 32'h3002, 32'h3004, 32'hA000_0001, 1'b1, 32'd2, S_RUN);
    chk("mis_pc.addr", {20'h0, imem_addr}, 32'h0);
    npc_val = 32'h7000;
    tick();
    chk("oor.addr", {20'h0, imem_addr}, 32'h0);
`ifdef PC_FETCH_CHECK_EN
    chk_all("mis_load", 32'h7000, 32'h3002, 32'h0, 1'b0, 32'd2, S_RUN);
    chk("mis_load.err", {31'h0, fetch_err}, 32'h1);
`else
    chk_all("mis_load", 32'h7000, 32'h3002, 32'hA000_0000, 1'b1, 32'd3, S_RUN);
`endif
    npc_force = 1'b0;
    tick();
    chk("oor_next.addr", {20'h0, imem_addr}, 32'h1);
`ifdef PC_FETCH_CHECK_EN
    chk_all("oor_load", 32'h7004, 32'h7000, 32'h0, 1'b0, 32'd2, S_RUN);
    chk("oor_load.err", {31'h0, fetch_err}, 32'h1);
`else
    chk_all("oor_load", 32'h7004, 32'h7000, 32'hA000_0000, 1'b1, 32'd4, S_RUN);
`endif

    // Reset clears the sticky error and everything else
    #2;
    reset = 1'b1;
    #1;
    chk_all("final_rst", 32'h3000, 32'h0, 32'h0, 1'b0, 32'd0, S_BOOT);
`ifdef PC_FETCH_CHECK_EN
    chk("final_rst.err", {31'h0, fetch_err}, 32'h0);
`endif
    tick();
    reset = 1'b0;

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch-stage block at the consumer end of the next-PC interface.
- Holds the architectural PC and drives it to the next-PC logic and to instruction memory.
- Loads the next-PC value each cycle unless stalled.
- Owns the IF/ID pipeline register (instr, pc, valid), a small sequencing FSM, and a fetch counter.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IMEM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- ADDR_W, 12, instruction-memory word-address width (4096 words).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hazard-unit stall; freezes PC and IF/ID
- flush  input  1  clear IF/ID to a bubble
- npc_in  input  32  next PC from next-PC logic (combinational, D-stage based)
- imem_rdata  input  32  instruction word at imem_addr (combinational read)
- pc_f  output  32  current fetch PC; also feeds next-PC logic
- imem_addr  output  ADDR_W  word address into instruction memory
- instr_d  output  32  IF/ID instruction
- pc_d  output  32  IF/ID PC
- valid_d  output  1  IF/ID holds a real fetched instruction
- fetch_cnt  output  32  count of instructions accepted into IF/ID

Behaviour:
- Reset (async, active-high), applied immediately:
  - pc_f=PC_RESET; instr_d=0; pc_d=0; valid_d=0; fetch_cnt=0; FSM=BOOT.
- imem_addr = (pc_f - IMEM_BASE) >> 2, truncated to ADDR_W bits. Wraps modulo 2^ADDR_W; no error.
- FSM states BOOT, RUN, HOLD:
  - BOOT: first edge after reset release. PC loads npc_in; IF/ID loads {imem_rdata, pc_f}, valid_d=1. Next state RUN. If stall=1 in BOOT, stay in BOOT with everything held.
  - RUN, stall=0: pc_f<=npc_in. If flush=0, IF/ID<={imem_rdata, pc_f, 1}. If flush=1, IF/ID<={0, 0, 0}.
  - RUN, stall=1: go to HOLD; pc_f and IF/ID unchanged.
  - HOLD: hold while stall=1. On stall=0, behave exactly as RUN with stall=0 in that cycle, then return to RUN.
- Priority: stall over flush. When both are 1, everything holds and the flush is dropped; the hazard unit must reassert flush.
- npc_in is taken as-is, with no alignment masking on pc_f. imem_addr ignores bits [1:0].
- fetch_cnt increments by 1 on each edge where IF/ID loads with valid=1. It saturates at 32'hFFFF_FFFF.
- Latency: npc_in presented in cycle N appears on pc_f in cycle N+1. Its instruction appears on instr_d in cycle N+2 if no stall or flush intervenes.
- Reset mid-stall or mid-flush returns to BOOT state immediately; no held state survives.

Optional Feature:
- Macro: PC_FETCH_CHECK_EN.
- Defined:
  - Adds output fetch_err (1 bit, reset 0).
  - On an IF/ID load, fetch_err<=1 if pc_f[1:0]!=0 or pc_f is outside [IMEM_BASE, IMEM_BASE+4*2^ADDR_W).
  - In that case IF/ID loads instr 0 with valid_d=0, and fetch_cnt does not increment.
  - fetch_err stays 1 until reset.
- Undefined:
  - No fetch_err port.
  - Out-of-range or misaligned PCs fetch whatever imem_rdata returns at the wrapped address.

Decomposition:
- Shared package holds:
  - PC_RESET_DEFAULT and IMEM_BASE_DEFAULT constants.
  - NOP_INSTR = 32'h0.
  - The 2-bit fetch-state encoding: BOOT=0, RUN=1, HOLD=2.
- One natural sub-module, if_id_reg: the IF/ID register with stall/flush/valid, reused later for other pipeline latches.
- The PC register and FSM stay in pc_fetch.

Test Plan:
- Reset release, stall=0, npc_in=pc_f+4, imem_rdata=mem[addr] -> cycle1 pc_f=0x3000, imem_addr=0; cycle2 pc_f=0x3004, pc_d=0x3000, valid_d=1; fetch_cnt=1.
- Redirect: pc_f=0x3008 and npc_in=0x3040 -> next pc_f=0x3040, imem_addr=0x10; pc_d=0x3008 (delay slot kept).
- stall=1 for 3 cycles at pc_f=0x300C -> pc_f, instr_d, pc_d and fetch_cnt all constant; FSM in HOLD; resumes with pc_f=npc_in after release.
- flush=1 with stall=0 -> instr_d=0, pc_d=0, valid_d=0, fetch_cnt unchanged. With stall=1 and flush=1 -> no change.
- Assert reset asynchronously mid-cycle during HOLD -> all outputs return to reset values before the next edge; FSM in BOOT.
- PC_FETCH_CHECK_EN: npc_in=0x3002 -> following load gives fetch_err=1, valid_d=0. npc_in=0x7000 (ADDR_W=12, out of range) -> fetch_err=1, sticky until reset.
